// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the VGA raster stage.
// Holds the default 640x480@60 Hz timing (100 MHz system clock, 25 MHz pixel rate) and the derived
// line/frame totals. It also holds the sync polarity, the counter width, the 12-bit colour type and
// a small window-decode helper.
package vga_timing_gen_pkg;

  localparam int unsigned CLK_DIV = 4;

  localparam int unsigned H_VIS   = 640;
  localparam int unsigned H_FP    = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BP    = 48;
  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;  // 800

  localparam int unsigned V_VIS   = 480;
  localparam int unsigned V_FP    = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BP    = 33;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;  // 525

  localparam int unsigned CNT_W = 10;

  // Both syncs are active low.
  localparam logic SYNC_ACTIVE = 1'b0;

  // {R[3:0], G[3:0], B[3:0]}
  typedef logic [11:0] colour_t;

  // Inclusive window test on a raster counter.
  function automatic logic in_window(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/vga_pixel_counter.sv
// Pixel-rate divider plus horizontal/vertical raster counters.
// Ports:
//   CLK        system clock
//   RESET      asynchronous active-low reset
//   pix_tick_o one-CLK strobe per pixel (last CLK of each divider period)
//   hcount_o   horizontal position 0..H_TOTAL-1, advances on pix_tick_o
//   vcount_o   vertical position 0..V_TOTAL-1, advances when hcount_o wraps
module vga_pixel_counter #(
  parameter int unsigned CLK_DIV = vga_timing_gen_pkg::CLK_DIV,
  parameter int unsigned H_TOTAL = vga_timing_gen_pkg::H_TOTAL,
  parameter int unsigned V_TOTAL = vga_timing_gen_pkg::V_TOTAL
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  output logic                                 pix_tick_o,
  output logic [vga_timing_gen_pkg::CNT_W-1:0] hcount_o,
  output logic [vga_timing_gen_pkg::CNT_W-1:0] vcount_o
);
  import vga_timing_gen_pkg::*;

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0]  DivLast = DivW'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HLast   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VLast   = CNT_W'(V_TOTAL - 1);

  logic [DivW-1:0]  div_q, div_d;
  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             tick;

  always_comb begin
    tick     = (div_q == DivLast);
    div_d    = tick ? '0 : div_q + 1'b1;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (tick) begin
      hcount_d = (hcount_q == HLast) ? '0 : hcount_q + 1'b1;
      if (hcount_q == HLast) begin
        vcount_d = (vcount_q == VLast) ? '0 : vcount_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      div_q    <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign pix_tick_o = tick;
  assign hcount_o   = hcount_q;
  assign vcount_o   = vcount_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: 640x480@60 Hz from a 100 MHz clock by default.
// Publishes the pixel address to the colour generator, takes its colour back one CLK later and
// drives blanked colour plus HS/VS, all describing the same pixel.
// Ports:
//   CLK         system clock
//   RESET       asynchronous active-low reset
//   COLOUR_IN   {R,G,B} for the current ADDRH/ADDRV, valid 1 CLK after the address changes
//   ADDRH       visible X coordinate (0 outside the visible area)
//   ADDRV       visible Y coordinate (0 outside the visible area)
//   COLOUR_OUT  registered pixel colour, 0 when blanked
//   HS, VS      horizontal / vertical sync, active low
//   PIX_TICK    one-CLK strobe per pixel
//   FRAME_START one-CLK pulse on the tick that moves the counters to (0,0), and on the first tick
//               after reset
module vga_timing_gen #(
  parameter int unsigned CLK_DIV = vga_timing_gen_pkg::CLK_DIV,
  parameter int unsigned H_VIS   = vga_timing_gen_pkg::H_VIS,
  parameter int unsigned H_FP    = vga_timing_gen_pkg::H_FP,
  parameter int unsigned H_SYNC  = vga_timing_gen_pkg::H_SYNC,
  parameter int unsigned H_BP    = vga_timing_gen_pkg::H_BP,
  parameter int unsigned V_VIS   = vga_timing_gen_pkg::V_VIS,
  parameter int unsigned V_FP    = vga_timing_gen_pkg::V_FP,
  parameter int unsigned V_SYNC  = vga_timing_gen_pkg::V_SYNC,
  parameter int unsigned V_BP    = vga_timing_gen_pkg::V_BP
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [11:0] COLOUR_IN,
  output logic [9:0]  ADDRH,
  output logic [8:0]  ADDRV,
  output logic [11:0] COLOUR_OUT,
  output logic        HS,
  output logic        VS,
  output logic        PIX_TICK,
  output logic        FRAME_START
);
  import vga_timing_gen_pkg::*;

  localparam int unsigned HTotal = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] HVis    = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] HSyncLo = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HSyncHi = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] HLast   = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] VVis    = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] VSyncLo = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VSyncHi = CNT_W'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] VLast   = CNT_W'(VTotal - 1);

  logic             pix_tick;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;

  vga_pixel_counter #(
    .CLK_DIV (CLK_DIV),
    .H_TOTAL (HTotal),
    .V_TOTAL (VTotal)
  ) u_pixel_counter (
    .CLK        (CLK),
    .RESET      (RESET),
    .pix_tick_o (pix_tick),
    .hcount_o   (hcount),
    .vcount_o   (vcount)
  );

  logic hs_raw, vs_raw, de;

  always_comb begin
    hs_raw = in_window(hcount, HSyncLo, HSyncHi) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_raw = in_window(vcount, VSyncLo, VSyncHi) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    de     = (hcount < HVis) && (vcount < VVis);
  end

  // The address registers capture the counters on the tick, so they trail the counters by one
  // pixel. The *_dly stage holds the raw decode of the pixel whose address is currently presented.
  // By the next tick, COLOUR_IN for that address has settled and the colour and syncs leave together.
  logic [9:0] addrh_q, addrh_d;
  logic [8:0] addrv_q, addrv_d;
  logic       hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d, de_dly_q, de_dly_d;
  logic       hs_q, hs_d, vs_q, vs_d;
  colour_t    colour_q, colour_d;
  logic       first_q, first_d;

  always_comb begin
    addrh_d  = addrh_q;
    addrv_d  = addrv_q;
    hs_dly_d = hs_dly_q;
    vs_dly_d = vs_dly_q;
    de_dly_d = de_dly_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    colour_d = colour_q;
    first_d  = first_q;
    if (pix_tick) begin
      addrh_d  = (hcount < HVis) ? hcount : '0;
      addrv_d  = (vcount < VVis) ? vcount[8:0] : '0;
      hs_dly_d = hs_raw;
      vs_dly_d = vs_raw;
      de_dly_d = de;
      hs_d     = hs_dly_q;
      vs_d     = vs_dly_q;
      colour_d = de_dly_q ? colour_t'(COLOUR_IN) : '0;
      first_d  = 1'b0;
    end
  end

  // Sync stages reset inactive so a restart never emits a partial pulse.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addrh_q  <= '0;
      addrv_q  <= '0;
      hs_dly_q <= ~SYNC_ACTIVE;
      vs_dly_q <= ~SYNC_ACTIVE;
      de_dly_q <= 1'b0;
      hs_q     <= ~SYNC_ACTIVE;
      vs_q     <= ~SYNC_ACTIVE;
      colour_q <= '0;
      first_q  <= 1'b1;
    end else begin
      addrh_q  <= addrh_d;
      addrv_q  <= addrv_d;
      hs_dly_q <= hs_dly_d;
      vs_dly_q <= vs_dly_d;
      de_dly_q <= de_dly_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      colour_q <= colour_d;
      first_q  <= first_d;
    end
  end

  assign ADDRH       = addrh_q;
  assign ADDRV       = addrv_q;
  assign COLOUR_OUT  = colour_q;
  assign HS          = hs_q;
  assign VS          = vs_q;
  assign PIX_TICK    = pix_tick;
  assign FRAME_START = pix_tick && (first_q || ((hcount == HLast) && (vcount == VLast)));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Instance 0 uses the default 640x480 timing, and instance 1 uses a
// shrunken raster (25x11) so that whole frames, the frame wrap and VS fit in a short run.
// The driver predicts every pixel tick and pushes the expected outputs into a scoreboard queue.
// The monitor pops one entry per DUT PIX_TICK and compares.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  addrh;
    logic [8:0]  addrv;
    logic [11:0] col;
    logic        hs;
    logic        vs;
    logic        fs;
  } out_t;

  typedef struct packed {
    int unsigned cyc;
    out_t [1:0]  o;
  } exp_t;

  logic        CLK;
  logic        RESET;
  logic [11:0] col_in      [2];
  logic [9:0]  addrh       [2];
  logic [8:0]  addrv       [2];
  logic [11:0] col_out     [2];
  logic        hs          [2];
  logic        vs          [2];
  logic        pix_tick    [2];
  logic        frame_start [2];

  bit          mode = 1'b0;   // 0: address pattern, 1: constant 12'hFFF
  bit          done = 1'b0;
  int unsigned cyc  = 0;
  int unsigned k    = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb_q[$];

  vga_timing_gen u_dut_full (
    .CLK         (CLK),
    .RESET       (RESET),
    .COLOUR_IN   (col_in[0]),
    .ADDRH       (addrh[0]),
    .ADDRV       (addrv[0]),
    .COLOUR_OUT  (col_out[0]),
    .HS          (hs[0]),
    .VS          (vs[0]),
    .PIX_TICK    (pix_tick[0]),
    .FRAME_START (frame_start[0])
  );

  vga_timing_gen #(
    .CLK_DIV (4),
    .H_VIS   (16),
    .H_FP    (2),
    .H_SYNC  (4),
    .H_BP    (3),
    .V_VIS   (6),
    .V_FP    (1),
    .V_SYNC  (2),
    .V_BP    (2)
  ) u_dut_small (
    .CLK         (CLK),
    .RESET       (RESET),
    .COLOUR_IN   (col_in[1]),
    .ADDRH       (addrh[1]),
    .ADDRV       (addrv[1]),
    .COLOUR_OUT  (col_out[1]),
    .HS          (hs[1]),
    .VS          (vs[1]),
    .PIX_TICK    (pix_tick[1]),
    .FRAME_START (frame_start[1])
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Upstream colour generator: registered lookup of the presented address.
  always_ff @(posedge CLK) begin
    col_in[0] <= mode ? 12'hFFF : {addrh[0][3:0], addrv[0][3:0], 4'hA};
    col_in[1] <= mode ? 12'hFFF : {addrh[1][3:0], addrv[1][3:0], 4'hA};
  end

  // CLK edges since the last reset release.
  initial begin
    forever begin
      @(posedge CLK or negedge RESET);
      if (!RESET) cyc = 0;
      else        cyc = cyc + 1;
    end
  end

  // Expected outputs just after the k-th tick since reset release (k >= 1).
  function automatic out_t model(input int idx, input int unsigned kk, input bit m);
    int unsigned hv, hfp, hsw, ht, vv, vfp, vsw, vt, f, c, h, v, p, ph, pv;
    out_t o;
    if (idx == 0) begin
      hv = 640; hfp = 16; hsw = 96; ht = 800; vv = 480; vfp = 10; vsw = 2; vt = 525;
    end else begin
      hv = 16;  hfp = 2;  hsw = 4;  ht = 25;  vv = 6;   vfp = 1;  vsw = 2; vt = 11;
    end
    f = ht * vt;
    c = (kk - 1) % f;
    h = c % ht;
    v = c / ht;
    o.addrh = (h < hv) ? 10'(h) : 10'd0;
    o.addrv = (v < vv) ? 9'(v) : 9'd0;
    o.hs    = 1'b1;
    o.vs    = 1'b1;
    o.col   = 12'h000;
    if (kk >= 2) begin
      p  = (kk - 2) % f;
      ph = p % ht;
      pv = p / ht;
      o.hs = (ph >= hv + hfp && ph < hv + hfp + hsw) ? 1'b0 : 1'b1;
      o.vs = (pv >= vv + vfp && pv < vv + vfp + vsw) ? 1'b0 : 1'b1;
      if (ph < hv && pv < vv) o.col = m ? 12'hFFF : {ph[3:0], pv[3:0], 4'hA};
    end
    o.fs = (kk == 1) || (c == f - 1);
    return o;
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got 0x%0h, expected 0x%0h", name, inst, $time, act, exp);
    end
  endtask

  // Monitor: reset values while RESET is low (also checked right after an asynchronous assertion),
  // otherwise held/updated outputs every CLK and a scoreboard pop on each PIX_TICK.
  initial begin
    out_t [1:0] cur;
    out_t       rst_o;
    exp_t       e;
    exp_t       pend;
    bit         pend_v;
    bit         done_chk;
    bit         tick_exp;
    rst_o    = '{addrh: 10'd0, addrv: 9'd0, col: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};
    cur      = {rst_o, rst_o};
    pend     = '0;
    pend_v   = 1'b0;
    done_chk = 1'b0;
    forever begin
      @(negedge CLK or negedge RESET);
      #1;
      if (done && !done_chk) begin
        chk("sb_leftover", 0, 32'(sb_q.size()), 32'd0);
        done_chk = 1'b1;
      end
      if (!RESET) begin
        pend_v = 1'b0;
        cur    = {rst_o, rst_o};
        for (int i = 0; i < 2; i++) begin
          chk("rst_addrh", i, 32'(addrh[i]), 32'd0);
          chk("rst_addrv", i, 32'(addrv[i]), 32'd0);
          chk("rst_colour", i, 32'(col_out[i]), 32'd0);
          chk("rst_hs", i, 32'(hs[i]), 32'd1);
          chk("rst_vs", i, 32'(vs[i]), 32'd1);
          chk("rst_pix_tick", i, 32'(pix_tick[i]), 32'd0);
          chk("rst_frame_start", i, 32'(frame_start[i]), 32'd0);
        end
      end else begin
        if (pend_v) begin
          cur    = pend.o;
          pend_v = 1'b0;
        end
        tick_exp = (cyc % 4 == 3);
        for (int i = 0; i < 2; i++) begin
          chk("pix_tick", i, 32'(pix_tick[i]), 32'(tick_exp));
          chk("addrh", i, 32'(addrh[i]), 32'(cur[i].addrh));
          chk("addrv", i, 32'(addrv[i]), 32'(cur[i].addrv));
          chk("colour_out", i, 32'(col_out[i]), 32'(cur[i].col));
          chk("hs", i, 32'(hs[i]), 32'(cur[i].hs));
          chk("vs", i, 32'(vs[i]), 32'(cur[i].vs));
        end
        if (pix_tick[0] || pix_tick[1]) begin
          if (sb_q.size() == 0) begin
            chk("sb_underflow", 0, 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("tick_cycle", 0, cyc, e.cyc);
            for (int i = 0; i < 2; i++) begin
              chk("frame_start", i, 32'(frame_start[i]), 32'(e.o[i].fs));
            end
            pend   = e;
            pend_v = 1'b1;
          end
        end else begin
          for (int i = 0; i < 2; i++) begin
            chk("frame_start_idle", i, 32'(frame_start[i]), 32'd0);
          end
        end
      end
    end
  end

  // Each tick k is the (4k-1)-th CLK after release; its expectation is queued before it happens.
  task automatic run_ticks(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      k     = k + 1;
      e.cyc = 4 * k - 1;
      e.o   = {model(1, k, mode), model(0, k, mode)};
      sb_q.push_back(e);
      repeat (4) @(posedge CLK);
    end
  endtask

  initial begin
    RESET = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    k     = 0;
    // Address pattern: 920 ticks covers a full default line and three-plus small frames, and it
    // leaves the small raster inside its HS pulse on visible line 3.
    run_ticks(920);
    // Asynchronous reset between edges, held for about three CLKs.
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    sb_q.delete();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    mode  = 1'b1;
    RESET = 1'b1;
    k     = 0;
    // All-white source: blanking must still force zero outside the visible area.
    run_ticks(830);
    done = 1'b1;
    repeat (3) @(negedge CLK);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Downstream raster stage for the VGA display state machines: generates 640x480@60 Hz timing from the 100 MHz system clock.
- Publishes the current pixel address (ADDRH/ADDRV) to the colour generator and accepts its 12-bit colour one CLK later.
- Drives the registered, blanked COLOUR_OUT and the HS/VS sync outputs, pipeline-aligned, to the board VGA connector.

Parameters:
- CLK_DIV, 4, CLK cycles per pixel (100 MHz -> 25 MHz pixel rate)
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels); line total 800
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); frame total 525

Ports:
- CLK  in  1  system clock, 100 MHz
- RESET  in  1  asynchronous, active-low reset
- COLOUR_IN  in  12  {R[3:0],G[3:0],B[3:0]} for the current address, valid 1 CLK after address change
- ADDRH  out  10  visible X coordinate 0..639
- ADDRV  out  9  visible Y coordinate 0..479
- COLOUR_OUT  out  12  pixel colour to DAC, 0 when blanked
- HS  out  1  horizontal sync, active low
- VS  out  1  vertical sync, active low
- PIX_TICK  out  1  one-CLK strobe per pixel
- FRAME_START  out  1  one-CLK pulse at pixel (0,0)

Behaviour:
- Clock and reset: one clock, CLK; RESET is asynchronous, active-low. While RESET=0: divider=0, hcount=0, vcount=0, ADDRH=0, ADDRV=0, COLOUR_OUT=0, HS=1, VS=1, PIX_TICK=0, FRAME_START=0.
- Pixel divider: counter 0..CLK_DIV-1, wraps. PIX_TICK=1 for the CLK where divider==CLK_DIV-1; first tick is the 4th CLK after reset release.
- Horizontal counter hcount 0..799 advances on PIX_TICK; at 799 it wraps to 0.
- Vertical counter vcount 0..524 increments on that same tick; at 524 it wraps to 0 together with hcount.
- Address outputs (registered, follow the counters):
  - ADDRH = hcount when hcount<640, else 0.
  - ADDRV = vcount when vcount<480, else 0.
- Raw sync and enable, from counters:
  - hs_raw low for hcount in [656,751].
  - vs_raw low for vcount in [490,491].
  - de = (hcount<640) && (vcount<480).
- Alignment pipeline: on each PIX_TICK:
  - COLOUR_OUT <= de_d ? COLOUR_IN : 0.
  - HS <= hs_d, VS <= vs_d, where *_d are the previous pixel's raw values.
  - Result: COLOUR_OUT, HS and VS describe the same pixel, one pixel period after its address was presented. COLOUR_IN is therefore sampled 4 CLK after the address change, which covers the upstream 1-CLK registered latency.
- Between ticks, all outputs hold their value.
- FRAME_START = 1 for exactly the CLK on which the counters move to (0,0); it is also asserted on the first tick after reset.
- Widths: hcount 10 bits, vcount 10 bits internally; ADDRV is the low 9 bits and is valid only because it is clamped to the visible range.
- Reset mid-frame: all state returns to reset values immediately (asynchronous assertion). The next frame starts cleanly at (0,0) with no partial sync pulse.
- No other state machine; the counters are the sequencing.

Decomposition:
- Shared package holds:
  - VGA timing constants (H_VIS..V_BP, derived H_TOTAL=800, V_TOTAL=525).
  - Sync polarity constant (active low).
  - 12-bit colour typedef.
- Natural sub-module: vga_pixel_counter, the divider plus h/v counters producing hcount, vcount and PIX_TICK. The top adds address clamping, sync decode and the alignment pipeline.

Test Plan:
- Reset then release; count ticks -> first PIX_TICK at CLK 4; HS=VS=1 and COLOUR_OUT=0 throughout reset.
- Run one line -> exactly 800 PIX_TICKs; HS low for exactly 96 ticks, starting 657 ticks after hcount=0 (one-pixel pipeline delay); ADDRH sequences 0..639 then holds 0 for 160 ticks.
- Run one frame -> 420,000 ticks between FRAME_START pulses; VS low for 2 lines (1600 ticks); ADDRV reaches 479 and never exceeds it.
- Drive COLOUR_IN = {ADDRH[3:0], ADDRV[3:0], 4'hA} with 1-CLK registered latency -> COLOUR_OUT at each tick equals the value for the previous tick's address. COLOUR_OUT=0 at hcount 640..799 and at vcount ≥480, even with COLOUR_IN=12'hFFF.
- Assert RESET=0 at hcount=700, vcount=300 for 3 CLK asynchronously, between edges -> outputs reset on assertion without waiting for CLK; after release, FRAME_START occurs on the first tick and HS/VS stay high until hcount 656.
- Check wrap at hcount=799, vcount=524 -> both counters go to 0 on the same tick, FRAME_START=1 for one CLK, and no extra VS pulse.
